// File: rtl/seg_disp_arbiter.sv
// Round-robin arbiter for two requesters driving a bank of hex digit registers.
// Optional per-digit blink mask, enabled by defining SEG_BLINK_EN.
module seg_disp_arbiter #(
   parameter int DIGITS    = 8,
   parameter int BLINK_DIV = 25000000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a_valid,
   output logic                  a_ready,
   input  logic [2:0]            a_idx,
   input  logic [1:0]            a_op,
   input  logic [3:0]            a_val,
   input  logic                  b_valid,
   output logic                  b_ready,
   input  logic [2:0]            b_idx,
   input  logic [1:0]            b_op,
   input  logic [3:0]            b_val,
   output logic [4*DIGITS-1:0]   digits,
   output logic [DIGITS-1:0]     dig_en
);

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_BLANK = 2'b01;
   localparam logic [1:0] OP_TOGL  = 2'b10;
   localparam logic [1:0] OP_WRBL  = 2'b11;

   logic [DIGITS-1:0][3:0] val_q, val_d;
   logic [DIGITS-1:0]      en_q, en_d;
   logic [DIGITS-1:0]      blink_q, blink_d;
   logic                   last_b_q, last_b_d;
   logic                   a_gnt, b_gnt, c_vld;
   logic [2:0]             c_idx;
   logic [1:0]             c_op;
   logic [3:0]             c_val;

   // Ties go to whichever requester was not served last; readies are dead in reset.
   always_comb begin
      a_gnt    = a_valid & (~b_valid | last_b_q);
      b_gnt    = b_valid & ~a_gnt;
      a_ready  = a_gnt & rst_n;
      b_ready  = b_gnt & rst_n;
      c_vld    = a_gnt | b_gnt;
      c_idx    = a_gnt ? a_idx : b_idx;
      c_op     = a_gnt ? a_op  : b_op;
      c_val    = a_gnt ? a_val : b_val;
      last_b_d = b_gnt ? 1'b1 : (a_gnt ? 1'b0 : last_b_q);
   end

   always_comb begin
      val_d   = val_q;
      en_d    = en_q;
      blink_d = blink_q;
      // Out-of-range indices match no digit, so they are accepted with no effect.
      for (int i = 0; i < DIGITS; i++) begin
         if (c_vld && c_idx == 3'(i)) begin
            case (c_op)
               OP_WRITE: begin
                  val_d[i] = c_val;
                  en_d[i]  = 1'b1;
               end
               OP_BLANK: en_d[i] = 1'b0;
`ifdef SEG_BLINK_EN
               OP_TOGL:  blink_d[i] = ~blink_q[i];
               OP_WRBL: begin
                  val_d[i]   = c_val;
                  en_d[i]    = 1'b1;
                  blink_d[i] = 1'b1;
               end
`else
               OP_TOGL:  ;
               OP_WRBL: begin
                  val_d[i] = c_val;
                  en_d[i]  = 1'b1;
               end
`endif
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val_q    <= '0;
         en_q     <= '0;
         last_b_q <= 1'b1;
      end else begin
         val_q    <= val_d;
         en_q     <= en_d;
         last_b_q <= last_b_d;
      end
   end

   assign digits = val_q;

`ifdef SEG_BLINK_EN
   localparam int CW = $clog2(BLINK_DIV);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;

   // Free-running half-period counter; commands never disturb it.
   always_comb begin
      cnt_d   = cnt_q + 1'b1;
      phase_d = phase_q;
      if (cnt_q == CW'(BLINK_DIV - 1)) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_q <= '0;
         cnt_q   <= '0;
         phase_q <= 1'b1;
      end else begin
         blink_q <= blink_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign dig_en = en_q & ~(blink_q & {DIGITS{~phase_q}});
`else
   // Mask storage is tied off so the non-blink build keeps no blink state.
   assign blink_q = '0;
   assign dig_en  = en_q;
`endif

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Directed bench for seg_disp_arbiter: handshake, round-robin, opcodes, reset.
// DIGITS=7 so that index 7 exercises the out-of-range path.
module tb_seg_disp_arbiter;

   localparam int D = 7;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic a_valid = 1'b0, b_valid = 1'b0;
   logic a_ready, b_ready;
   logic [2:0] a_idx = '0, b_idx = '0;
   logic [1:0] a_op = '0, b_op = '0;
   logic [3:0] a_val = '0, b_val = '0;
   logic [4*D-1:0] digits;
   logic [D-1:0] dig_en;

   int n_pass = 0;
   int n_tot  = 0;
   int ecnt   = 0;

   always #5 clk = ~clk;

   // Edges since reset release, used as the blink-phase reference.
   always @(posedge clk or negedge rst_n)
      if (!rst_n) ecnt <= 0;
      else        ecnt <= ecnt + 1;

   seg_disp_arbiter #(.DIGITS(D), .BLINK_DIV(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_idx(a_idx), .a_op(a_op), .a_val(a_val),
      .b_valid(b_valid), .b_ready(b_ready), .b_idx(b_idx), .b_op(b_op), .b_val(b_val),
      .digits(digits), .dig_en(dig_en)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(input logic v, input logic [2:0] i, input logic [1:0] o, input logic [3:0] x);
      a_valid = v; a_idx = i; a_op = o; a_val = x;
   endtask

   task automatic set_b(input logic v, input logic [2:0] i, input logic [1:0] o, input logic [3:0] x);
      b_valid = v; b_idx = i; b_op = o; b_val = x;
   endtask

   initial begin
      // Reset: outputs zero, readies forced low even with valid high.
      set_a(1'b1, 3'd0, 2'b00, 4'h1);
      set_b(1'b1, 3'd0, 2'b00, 4'h2);
      tick(); tick();
      chk("rst_digits", 64'(digits), 64'h0);
      chk("rst_dig_en", 64'(dig_en), 64'h0);
      chk("rst_a_ready", 64'(a_ready), 64'h0);
      chk("rst_b_ready", 64'(b_ready), 64'h0);
      set_a(1'b0, 3'd0, 2'b00, 4'h0);
      set_b(1'b0, 3'd0, 2'b00, 4'h0);
      rst_n = 1'b1;

      // A WRITE idx3 0xA.
      set_a(1'b1, 3'd3, 2'b00, 4'hA);
      #1 chk("wr_a_ready", 64'(a_ready), 64'h1);
      tick();
      set_a(1'b0, 3'd0, 2'b00, 4'h0);
      chk("wr_digit3", 64'(digits[15:12]), 64'hA);
      chk("wr_dig_en", 64'(dig_en), 64'b0001000);

      // Contention: A served last, so B wins first, then alternation.
      set_a(1'b1, 3'd0, 2'b00, 4'h1);
      set_b(1'b1, 3'd0, 2'b00, 4'h2);
      #1 chk("ct1_b_ready", 64'({a_ready, b_ready}), 64'b01);
      tick(); chk("ct1_digit0", 64'(digits[3:0]), 64'h2);
      chk("ct2_a_ready", 64'({a_ready, b_ready}), 64'b10);
      tick(); chk("ct2_digit0", 64'(digits[3:0]), 64'h1);
      chk("ct3_b_ready", 64'({a_ready, b_ready}), 64'b01);
      tick(); chk("ct3_digit0", 64'(digits[3:0]), 64'h2);
      chk("ct4_a_ready", 64'({a_ready, b_ready}), 64'b10);
      tick(); chk("ct4_digit0", 64'(digits[3:0]), 64'h1);
      set_a(1'b0, 3'd0, 2'b00, 4'h0);
      set_b(1'b0, 3'd0, 2'b00, 4'h0);
      chk("ct_dig_en", 64'(dig_en), 64'b0001001);

      // B BLANK idx3: enable drops, value retained.
      set_b(1'b1, 3'd3, 2'b01, 4'h0);
      #1 chk("bl_b_ready", 64'(b_ready), 64'h1);
      tick();
      set_b(1'b0, 3'd0, 2'b00, 4'h0);
      chk("bl_dig_en", 64'(dig_en), 64'b0000001);
      chk("bl_digit3", 64'(digits[15:12]), 64'hA);

      // Out-of-range idx: accepted, no state change, pointer moves to A.
      set_a(1'b1, 3'd7, 2'b00, 4'hF);
      #1 chk("oor_a_ready", 64'(a_ready), 64'h1);
      tick();
      set_a(1'b0, 3'd0, 2'b00, 4'h0);
      chk("oor_digits", 64'(digits), 64'h000A001);
      chk("oor_dig_en", 64'(dig_en), 64'b0000001);

      // Tie after A grant: B first; A holds its command and is served next.
      set_a(1'b1, 3'd1, 2'b00, 4'h3);
      set_b(1'b1, 3'd2, 2'b00, 4'h4);
      #1 chk("tie_ready", 64'({a_ready, b_ready}), 64'b01);
      tick();
      set_b(1'b0, 3'd0, 2'b00, 4'h0);
      chk("tie_digits", 64'(digits), 64'h000A401);
      #1 chk("hold_a_ready", 64'(a_ready), 64'h1);
      tick();
      set_a(1'b0, 3'd0, 2'b00, 4'h0);
      chk("hold_digits", 64'(digits), 64'h000A431);
      chk("hold_dig_en", 64'(dig_en), 64'b0000111);

`ifdef SEG_BLINK_EN
      // WRITE_BLINK idx0: lit while phase=1, phase flips every N edges from reset.
      set_a(1'b1, 3'd0, 2'b11, 4'h5);
      tick();
      set_a(1'b0, 3'd0, 2'b00, 4'h0);
      chk("wb_digit0", 64'(digits[3:0]), 64'h5);
      for (int k = 0; k < 4 * N; k++) begin
         chk("blink_phase", 64'(dig_en[0]), 64'(~((ecnt / N) & 1)));
         tick();
      end
      set_a(1'b1, 3'd0, 2'b10, 4'h0);
      tick();
      set_a(1'b0, 3'd0, 2'b00, 4'h0);
      for (int k = 0; k < 2 * N + 1; k++) begin
         chk("untoggle_lit", 64'(dig_en[0]), 64'h1);
         tick();
      end
`else
      // WRITE_BLINK acts as WRITE; BLINK_TOGGLE is a no-op.
      set_a(1'b1, 3'd1, 2'b11, 4'h7);
      tick();
      set_a(1'b1, 3'd1, 2'b10, 4'h0);
      chk("wb_digit1", 64'(digits[7:4]), 64'h7);
      tick();
      set_a(1'b0, 3'd0, 2'b00, 4'h0);
      for (int k = 0; k < 20; k++) begin
         chk("steady_en1", 64'(dig_en[1]), 64'h1);
         tick();
      end
      chk("nb_digits", 64'(digits), 64'h000A471);
`endif

      // Asynchronous reset between edges with both requesters valid.
      set_a(1'b1, 3'd0, 2'b00, 4'h9);
      set_b(1'b1, 3'd5, 2'b00, 4'h6);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_digits", 64'(digits), 64'h0);
      chk("arst_dig_en", 64'(dig_en), 64'h0);
      chk("arst_ready", 64'({a_ready, b_ready}), 64'b00);
      tick();
      rst_n = 1'b1;
      #1 chk("post_rst_tie", 64'({a_ready, b_ready}), 64'b10);
      tick();
      set_a(1'b0, 3'd0, 2'b00, 4'h0);
      set_b(1'b0, 3'd0, 2'b00, 4'h0);
      chk("post_rst_digits", 64'(digits), 64'h0000009);
      chk("post_rst_dig_en", 64'(dig_en), 64'b0000001);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
